// File: rtl/tiles_pkg.sv
// Shared Piano Tiles definitions: sequencer state encoding and default
// geometry constants, also used by the VGA draw datapath.
package tiles_pkg;

  localparam int ROW_HEIGHT_DEF     = 40;
  localparam int ROWS_PER_LEVEL_DEF = 8;

  localparam logic [3:0] ST_IDLE         = 4'd0;
  localparam logic [3:0] ST_RESET_SCREEN = 4'd1;
  localparam logic [3:0] ST_DETECT_EDGE  = 4'd2;
  localparam logic [3:0] ST_EDGE_STUFF   = 4'd3;
  localparam logic [3:0] ST_CHECK_MISS   = 4'd4;
  localparam logic [3:0] ST_DRAW         = 4'd5;
  localparam logic [3:0] ST_WAIT         = 4'd6;
  localparam logic [3:0] ST_PAUSED       = 4'd7;
  localparam logic [3:0] ST_NEXT_ROW     = 4'd8;
  localparam logic [3:0] ST_GAME_OVER    = 4'd9;

  typedef enum logic [3:0] {
    IDLE         = ST_IDLE,
    RESET_SCREEN = ST_RESET_SCREEN,
    DETECT_EDGE  = ST_DETECT_EDGE,
    EDGE_STUFF   = ST_EDGE_STUFF,
    CHECK_MISS   = ST_CHECK_MISS,
    DRAW         = ST_DRAW,
    WAIT         = ST_WAIT,
    PAUSED       = ST_PAUSED,
    NEXT_ROW     = ST_NEXT_ROW,
    GAME_OVER    = ST_GAME_OVER
  } state_t;

endpackage

// File: rtl/tile_sequencer_scroll_counter.sv
// scroll_counter: scroll offset within a tile row, completed-row count and
// (with SPEEDUP_EN defined) the difficulty level. Without SPEEDUP_EN the
// level output is tied to zero and no level register exists.
module scroll_counter
  import tiles_pkg::*;
#(
  parameter int ROW_HEIGHT     = ROW_HEIGHT_DEF,
  parameter int OFFSET_W       = 6,
  parameter int ROW_CNT_W      = 10,
  parameter int LEVEL_W        = 3,
  parameter int ROWS_PER_LEVEL = ROWS_PER_LEVEL_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 step,
  output logic [OFFSET_W-1:0]  offset,
  output logic [ROW_CNT_W-1:0] row_count,
  output logic [LEVEL_W-1:0]   level,
  output logic                 wrap,
  output logic                 at_edge
);

  logic [ROW_CNT_W-1:0] row_next;

  assign at_edge  = (offset == OFFSET_W'(ROW_HEIGHT - 1));
  assign wrap     = step && at_edge;
  assign row_next = (row_count == '1) ? row_count : row_count + ROW_CNT_W'(1);

  // Offset steps once per frame and wraps at the row edge; each wrap is a completed row.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      offset    <= '0;
      row_count <= '0;
    end else if (clear) begin
      offset    <= '0;
      row_count <= '0;
    end else if (step) begin
      if (at_edge) begin
        offset    <= '0;
        row_count <= row_next;
      end else begin
        offset    <= offset + OFFSET_W'(1);
      end
    end
  end

`ifdef SPEEDUP_EN
  logic [LEVEL_W-1:0] level_q;

  // Level rises when a wrap lands the row count on a multiple of ROWS_PER_LEVEL; saturates.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level_q <= '0;
    end else if (clear) begin
      level_q <= '0;
    end else if (wrap && (row_count != '1) &&
                 ((row_next % ROW_CNT_W'(ROWS_PER_LEVEL)) == '0) &&
                 (level_q != '1)) begin
      level_q <= level_q + LEVEL_W'(1);
    end
  end

  assign level = level_q;
`else
  localparam int rows_per_level_unused = ROWS_PER_LEVEL;
  assign level = '0;
`endif

endmodule

// File: rtl/tile_sequencer.sv
// tile_sequencer: Piano Tiles master sequencer. Steps the scroll offset and
// starts the screen-clear, draw and frame-wait engines by go/done handshake.
// Optional feature macro: SPEEDUP_EN (difficulty level output).
module tile_sequencer
  import tiles_pkg::*;
#(
  parameter int ROW_HEIGHT     = ROW_HEIGHT_DEF,
  parameter int OFFSET_W       = 6,
  parameter int ROW_CNT_W      = 10,
  parameter int LEVEL_W        = 3,
  parameter int ROWS_PER_LEVEL = ROWS_PER_LEVEL_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 reset_screen_done,
  input  logic                 draw_done,
  input  logic                 wait_done,
  input  logic                 miss,
  input  logic                 pause,
  output logic                 reset_screen_go,
  output logic                 draw_go,
  output logic                 wait_go,
  output logic                 edge_go,
  output logic                 offset_increase,
  output logic [OFFSET_W-1:0]  offset,
  output logic [ROW_CNT_W-1:0] row_count,
  output logic                 game_over,
  output logic [LEVEL_W-1:0]   level
);

  state_t state;
  state_t next_state;
  logic   at_edge;
  logic   unused_wrap;

  // State register; reset aborts any engine handshake immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; inputs not relevant to the current state are ignored.
  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:         next_state = start ? RESET_SCREEN : IDLE;
      RESET_SCREEN: next_state = reset_screen_done ? DETECT_EDGE : RESET_SCREEN;
      DETECT_EDGE:  next_state = at_edge ? EDGE_STUFF : DRAW;
      EDGE_STUFF:   next_state = CHECK_MISS;
      CHECK_MISS:   next_state = miss ? GAME_OVER : DRAW;
      DRAW:         next_state = draw_done ? WAIT : DRAW;
      WAIT: begin
        if (wait_done)  next_state = NEXT_ROW;
        else if (pause) next_state = PAUSED;
        else            next_state = WAIT;
      end
      PAUSED:       next_state = pause ? PAUSED : WAIT;
      NEXT_ROW:     next_state = DETECT_EDGE;
      GAME_OVER:    next_state = start ? RESET_SCREEN : GAME_OVER;
      default:      next_state = IDLE;
    endcase
  end

  assign reset_screen_go = (state == RESET_SCREEN);
  assign draw_go         = (state == DRAW);
  assign wait_go         = (state == WAIT);
  assign edge_go         = (state == EDGE_STUFF);
  assign offset_increase = (state == NEXT_ROW);
  assign game_over       = (state == GAME_OVER);

  // Counters are cleared while the screen is being cleared and advance once per NEXT_ROW.
  scroll_counter #(
    .ROW_HEIGHT     (ROW_HEIGHT),
    .OFFSET_W       (OFFSET_W),
    .ROW_CNT_W      (ROW_CNT_W),
    .LEVEL_W        (LEVEL_W),
    .ROWS_PER_LEVEL (ROWS_PER_LEVEL)
  ) u_scroll (
    .clock     (clock),
    .reset     (reset),
    .clear     (state == RESET_SCREEN),
    .step      (state == NEXT_ROW),
    .offset    (offset),
    .row_count (row_count),
    .level     (level),
    .wrap      (unused_wrap),
    .at_edge   (at_edge)
  );

endmodule

// File: tb/tb_tile_sequencer.sv
// Directed bench for tile_sequencer: start-up, 64 rows of scrolling with a
// pause, miss game over, restart, and asynchronous reset during DRAW.
// Honours SPEEDUP_EN for the level expectations.
module tb_tile_sequencer;

  localparam int ROW_HEIGHT     = 40;
  localparam int OFFSET_W       = 6;
  localparam int ROW_CNT_W      = 10;
  localparam int LEVEL_W        = 3;
  localparam int ROWS_PER_LEVEL = 8;
`ifdef SPEEDUP_EN
  localparam bit SPD = 1'b1;
`else
  localparam bit SPD = 1'b0;
`endif

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 start;
  logic                 reset_screen_done;
  logic                 draw_done;
  logic                 wait_done;
  logic                 miss;
  logic                 pause;
  logic                 reset_screen_go;
  logic                 draw_go;
  logic                 wait_go;
  logic                 edge_go;
  logic                 offset_increase;
  logic [OFFSET_W-1:0]  offset;
  logic [ROW_CNT_W-1:0] row_count;
  logic                 game_over;
  logic [LEVEL_W-1:0]   level;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_off  = 0;
  int exp_rows = 0;
  int exp_lvl  = 0;

  tile_sequencer #(
    .ROW_HEIGHT     (ROW_HEIGHT),
    .OFFSET_W       (OFFSET_W),
    .ROW_CNT_W      (ROW_CNT_W),
    .LEVEL_W        (LEVEL_W),
    .ROWS_PER_LEVEL (ROWS_PER_LEVEL)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .reset_screen_done (reset_screen_done),
    .draw_done         (draw_done),
    .wait_done         (wait_done),
    .miss              (miss),
    .pause             (pause),
    .reset_screen_go   (reset_screen_go),
    .draw_go           (draw_go),
    .wait_go           (wait_go),
    .edge_go           (edge_go),
    .offset_increase   (offset_increase),
    .offset            (offset),
    .row_count         (row_count),
    .game_over         (game_over),
    .level             (level)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rsgo"}, int'(reset_screen_go), 0);
    chk({tag, "_drawgo"}, int'(draw_go), 0);
    chk({tag, "_waitgo"}, int'(wait_go), 0);
    chk({tag, "_edgego"}, int'(edge_go), 0);
    chk({tag, "_oinc"}, int'(offset_increase), 0);
    chk({tag, "_offset"}, int'(offset), 0);
    chk({tag, "_rows"}, int'(row_count), 0);
    chk({tag, "_gameover"}, int'(game_over), 0);
    chk({tag, "_level"}, int'(level), 0);
  endtask

  // Reference update for one NEXT_ROW.
  task automatic model_next_row();
    if (exp_off == ROW_HEIGHT - 1) begin
      exp_off = 0;
      if (exp_rows != 1023) exp_rows++;
      if (SPD && (exp_rows % ROWS_PER_LEVEL == 0) && exp_lvl != 7) exp_lvl++;
    end else begin
      exp_off++;
    end
  endtask

  // One frame starting in DETECT_EDGE. mode 0: normal, 1: pause in WAIT, 2: miss at CHECK_MISS.
  task automatic do_frame(input int mode);
    bit edge_exp;
    edge_exp = (exp_off == ROW_HEIGHT - 1);
    chk("de_offset", int'(offset), exp_off);
    chk("de_rows", int'(row_count), exp_rows);
    chk("de_level", int'(level), exp_lvl);
    chk("de_drawgo", int'(draw_go), 0);
    step();
    if (edge_exp) begin
      chk("edge_go", int'(edge_go), 1);
      chk("edge_offset", int'(offset), ROW_HEIGHT - 1);
      step();
      chk("cm_edge_go", int'(edge_go), 0);
      chk("cm_draw_go", int'(draw_go), 0);
      miss = (mode == 2);
      step();
      miss = 1'b0;
      if (mode == 2) begin
        chk("miss_game_over", int'(game_over), 1);
        return;
      end
    end
    chk("draw_go", int'(draw_go), 1);
    chk("draw_edge_go", int'(edge_go), 0);
    draw_done = 1'b1;
    step();
    draw_done = 1'b0;
    chk("wait_go", int'(wait_go), 1);
    chk("draw_go_drop", int'(draw_go), 0);
    if (mode == 1) begin
      pause = 1'b1;
      step();
      chk("paused_wait_go", int'(wait_go), 0);
      step();
      chk("paused_wait_go2", int'(wait_go), 0);
      pause = 1'b0;
      step();
      chk("resume_wait_go", int'(wait_go), 1);
      pause = 1'b1;
    end
    wait_done = 1'b1;
    step();
    wait_done = 1'b0;
    pause     = 1'b0;
    chk("oinc_pulse", int'(offset_increase), 1);
    chk("oinc_wait_go", int'(wait_go), 0);
    model_next_row();
    step();
    chk("oinc_single", int'(offset_increase), 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    reset_screen_done = 1'b0;
    draw_done = 1'b0;
    wait_done = 1'b0;
    miss = 1'b0;
    pause = 1'b0;
    step();
    step();
    chk_all_zero("in_reset");
    reset = 1'b0;
    step();
    chk_all_zero("idle");

    // Start-up handshake
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_rsgo", int'(reset_screen_go), 1);
    chk("start_drawgo", int'(draw_go), 0);
    chk("start_gameover", int'(game_over), 0);
    step();
    chk("rs_hold", int'(reset_screen_go), 1);
    reset_screen_done = 1'b1;
    step();
    reset_screen_done = 1'b0;
    chk("rs_done_drop", int'(reset_screen_go), 0);
    chk("rs_done_offset", int'(offset), 0);

    // 64 rows of scrolling, pause exercised in frame 2
    for (int f = 0; f < ROW_HEIGHT * 64; f++) begin
      do_frame((f == 2) ? 1 : 0);
      if (f == ROW_HEIGHT - 1) begin
        chk("row1_rows", int'(row_count), 1);
        chk("row1_offset", int'(offset), 0);
      end
    end
    chk("rows64", int'(row_count), 64);
    chk("level64", int'(level), SPD ? 7 : 0);

    // Scroll up to the edge and miss there
    for (int f = 0; f < ROW_HEIGHT - 1; f++) do_frame(0);
    do_frame(2);
    step();
    step();
    chk("go_hold", int'(game_over), 1);
    chk("go_offset", int'(offset), ROW_HEIGHT - 1);
    chk("go_rows", int'(row_count), 64);
    chk("go_level", int'(level), exp_lvl);
    chk("go_rsgo", int'(reset_screen_go), 0);

    // Restart clears the counters
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_rsgo", int'(reset_screen_go), 1);
    chk("restart_gameover", int'(game_over), 0);
    step();
    chk("restart_offset", int'(offset), 0);
    chk("restart_rows", int'(row_count), 0);
    chk("restart_level", int'(level), 0);
    reset_screen_done = 1'b1;
    step();
    reset_screen_done = 1'b0;
    exp_off = 0;
    exp_rows = 0;
    exp_lvl = 0;
    do_frame(0);

    // Asynchronous reset while drawing
    step();
    chk("pre_reset_drawgo", int'(draw_go), 1);
    chk("pre_reset_offset", int'(offset), 1);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("async_reset");
    step();
    reset = 1'b0;
    step();
    chk_all_zero("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
